alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Shares the single execute-stage ALU between two requesters: req 0 is the pipeline
//  execute path and req 1 is the address/auxiliary path. Round-robin arbitration picks
//  one requester, registers its operands and drives the shared ALU. The registered
//  result is returned over a valid/ready response channel tagged with the requester id.
//  One operation is in flight at a time.
// PARAMETERS
//  DATA_WIDTH   32  operand/result width
//  ALU_CONTROL  4   ALU opcode width
// PORTS
//  clk         in   1               clock, all state on rising edge
//  rst         in   1               asynchronous, active-high reset
//  req_valid_i in   2               bit i: requester i presents an operation
//  req_ready_o out  2               bit i: requester i granted/accepted this cycle
//  req_a_i     in   2*DATA_WIDTH    operand A; [DW-1:0]=req0, [2DW-1:DW]=req1
//  req_b_i     in   2*DATA_WIDTH    operand B, same packing
//  req_op_i    in   2*ALU_CONTROL   ALU opcode, same packing
//  alu_a_o     out  DATA_WIDTH      to ALU a_i
//  alu_b_o     out  DATA_WIDTH      to ALU b_i
//  alu_op_o    out  ALU_CONTROL     to ALU op
//  alu_res_i   in   DATA_WIDTH      from ALU result (combinational)
//  rsp_valid_o out  1               response holds a result
//  rsp_id_o    out  1               requester that owns the response
//  rsp_data_o  out  DATA_WIDTH      registered ALU result
//  rsp_ready_i in   1               consumer accepts the response
// BEHAVIOUR
//  Reset (async, any time incl. mid-op): state=IDLE; last_grant=1; op regs, rsp_data_o,
//   rsp_id_o, rsp_valid_o = 0; req_ready_o=0; in-flight operation discarded, no response.
//  FSM IDLE -> EXEC -> RESP -> IDLE:
//   IDLE: grant is combinational. If exactly one req_valid_i bit is set, grant it. If
//    both are set, grant the requester != last_grant. req_ready_o = onehot(grant) only in
//    IDLE, otherwise 0. On the clock edge with a grant, latch a/b/op and id, set
//    last_grant=id, and go to EXEC. With no valid, stay in IDLE.
//   EXEC: alu_*_o are driven from the op regs, which are the only source at all times.
//    On the edge, rsp_data_o<=alu_res_i, rsp_id_o<=id, rsp_valid_o<=1, go to RESP.
//   RESP: hold rsp_* stable while rsp_ready_i=0. On the edge with rsp_ready_i=1, set
//    rsp_valid_o<=0 and go to IDLE. No new grant occurs in RESP, even on the handshake
//    cycle.
//  Timing: accept at edge N, then rsp_valid_o=1 after edge N+1. Best throughput is one
//   op per 3 cycles.
//  Requester rule: valid must not depend on ready. Once raised, valid and payload are held
//   until ready. A requester that is not granted keeps waiting and gets no side effects.
//  Fairness: with both valid continuously, grants alternate 0,1,0,1... The first grant
//   after reset goes to 0.
//  Width: operands and result pass through unmodified. No arithmetic is done here.
//  req_valid_i changing during EXEC/RESP is ignored until IDLE.
// TESTING
//  1 Reset: assert rst mid-RESP -> rsp_valid_o=0 and req_ready_o=0 immediately, and
//    the next grant goes to req0.
//  2 Single op: req0 a=5 b=7 op=ADD -> req_ready_o=2'b01 in the accept cycle. Two cycles
//    later rsp_valid_o=1, id=0, data=12.
//  3 Contention: both valid continuously with rsp_ready_i=1 -> grant order 0,1,0,1 and
//    rsp_id_o sequence 0,1,0,1 with matching results.
//  4 Backpressure: rsp_ready_i=0 for 5 cycles during RESP -> rsp_data_o stays stable,
//    req_ready_o=0, and a pending req1 is granted in the cycle after the handshake.
//  5 Stability: req1 a=0xFFFFFFFF b=1 op=ADD; change req_a_i after acceptance ->
//    alu_a_o stays 0xFFFFFFFF and data=0x00000000.
//  6 Idle: no valid for 10 cycles -> state IDLE, req_ready_o=0, rsp_valid_o=0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one execute-stage ALU between two requesters
// Ports:
//   clk, rst                        clock and asynchronous active-high reset
//   req_valid_i / req_ready_o [1:0] per-requester valid and grant/accept
//   req_a_i, req_b_i, req_op_i      packed operands/opcode, requester 0 in the low slice
//   alu_a_o, alu_b_o, alu_op_o      registered operands to the shared ALU
//   alu_res_i                       combinational ALU result
//   rsp_valid_o, rsp_id_o,
//   rsp_data_o, rsp_ready_i         tagged valid/ready response channel
module alu_share_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int ALU_CONTROL = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 req_valid_i,
    output logic [1:0]                 req_ready_o,
    input  logic [2*DATA_WIDTH-1:0]    req_a_i,
    input  logic [2*DATA_WIDTH-1:0]    req_b_i,
    input  logic [2*ALU_CONTROL-1:0]   req_op_i,
    output logic [DATA_WIDTH-1:0]      alu_a_o,
    output logic [DATA_WIDTH-1:0]      alu_b_o,
    output logic [ALU_CONTROL-1:0]     alu_op_o,
    input  logic [DATA_WIDTH-1:0]      alu_res_i,
    output logic                       rsp_valid_o,
    output logic                       rsp_id_o,
    output logic [DATA_WIDTH-1:0]      rsp_data_o,
    input  logic                       rsp_ready_i
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t                 state_q, state_d;
    logic                   last_grant_q, last_grant_d;
    logic                   id_q, id_d;
    logic                   rsp_id_q, rsp_id_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]  a_q, a_d, b_q, b_d, rsp_data_q, rsp_data_d;
    logic [ALU_CONTROL-1:0] op_q, op_d;
    logic                   gnt_id, take, in_exec, in_resp;
    logic [1:0]             grant;
    always_comb begin
        // With both requesting, the one that did not win last time goes next.
        gnt_id       = (req_valid_i == 2'b11) ? ~last_grant_q : req_valid_i[1];
        // Grant is held off while reset is asserted so ready drops immediately.
        grant        = (state_q == IDLE && !rst) ? (req_valid_i & (2'b01 << gnt_id)) : 2'b00;
        take         = |grant;
        in_exec      = (state_q == EXEC);
        in_resp      = (state_q == RESP);
        a_d          = take ? req_a_i[gnt_id*DATA_WIDTH +: DATA_WIDTH] : a_q;
        b_d          = take ? req_b_i[gnt_id*DATA_WIDTH +: DATA_WIDTH] : b_q;
        op_d         = take ? req_op_i[gnt_id*ALU_CONTROL +: ALU_CONTROL] : op_q;
        id_d         = take ? gnt_id : id_q;
        last_grant_d = take ? gnt_id : last_grant_q;
        rsp_data_d   = in_exec ? alu_res_i : rsp_data_q;
        rsp_id_d     = in_exec ? id_q : rsp_id_q;
        rsp_valid_d  = in_exec ? 1'b1 : (in_resp && rsp_ready_i) ? 1'b0 : rsp_valid_q;
        state_d      = (state_q == IDLE) ? (take ? EXEC : IDLE) :
                       in_exec ? RESP : (rsp_ready_i ? IDLE : RESP);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            rsp_data_q   <= '0;
            rsp_id_q     <= 1'b0;
            rsp_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            rsp_data_q   <= rsp_data_d;
            rsp_id_q     <= rsp_id_d;
            rsp_valid_q  <= rsp_valid_d;
        end
    end
    assign req_ready_o = grant;
    assign alu_a_o     = a_q;
    assign alu_b_o     = b_q;
    assign alu_op_o    = op_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_data_o  = rsp_data_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: scoreboard bench for the shared-ALU arbiter with a behavioural ALU
module tb_alu_share_arbiter;
    localparam int DW = 32;
    localparam int AC = 4;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          v0 = 1'b0, v1 = 1'b0;
    logic [DW-1:0] a0 = '0, a1 = '0, b0 = '0, b1 = '0;
    logic [AC-1:0] o0 = '0, o1 = '0;
    logic          rsp_ready = 1'b1;
    logic [1:0]    req_ready;
    logic [DW-1:0] alu_a, alu_b, alu_res, rsp_data;
    logic [AC-1:0] alu_op;
    logic          rsp_valid, rsp_id;
    int            n_cmp = 0, n_err = 0;
    logic [DW:0]   sb[$];
    logic          glog[$];
    logic          last_m = 1'b1;

    always #5 clk = ~clk;

    alu_share_arbiter #(.DATA_WIDTH(DW), .ALU_CONTROL(AC)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i({v1, v0}), .req_ready_o(req_ready),
        .req_a_i({a1, a0}), .req_b_i({b1, b0}), .req_op_i({o1, o0}),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op), .alu_res_i(alu_res),
        .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id), .rsp_data_o(rsp_data),
        .rsp_ready_i(rsp_ready)
    );

    function automatic logic [DW-1:0] alu_f(logic [DW-1:0] a, logic [DW-1:0] b, logic [AC-1:0] op);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            default: return a;
        endcase
    endfunction

    assign alu_res = alu_f(alu_a, alu_b, alu_op);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Monitor: checks each grant against a round-robin model, pushes the expected
    // response at acceptance, pops and compares at each response handshake.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            sb.delete();
            glog.delete();
            last_m = 1'b1;
        end else begin
            if (req_ready != 2'b00) begin
                logic g;
                g = ({v1, v0} == 2'b11) ? ~last_m : v1;
                chk("grant", {62'd0, req_ready}, g ? 64'd2 : 64'd1);
                last_m = g;
                glog.push_back(g);
                sb.push_back(g ? {1'b1, alu_f(a1, b1, o1)} : {1'b0, alu_f(a0, b0, o0)});
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) chk("rsp_unexpected", 64'd1, 64'd0);
                else begin
                    logic [DW:0] e;
                    e = sb.pop_front();
                    chk("rsp_id", {63'd0, rsp_id}, {63'd0, e[DW]});
                    chk("rsp_data", {32'd0, rsp_data}, {32'd0, e[DW-1:0]});
                end
            end
        end
    end

    task automatic issue(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [AC-1:0] op);
        if (id == 0) begin v0 = 1'b1; a0 = a; b0 = b; o0 = op; end
        else begin v1 = 1'b1; a1 = a; b1 = b; o1 = op; end
    endtask

    task automatic drop(input int id);
        if (id == 0) v0 = 1'b0; else v1 = 1'b0;
    endtask

    task automatic wait_ready(input int id);
        int k;
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (req_ready[id]) break;
        end
        if (k == 100) chk("accept_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic wait_rsp();
        int k;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_valid) break;
        end
        if (k == 20) chk("rsp_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && !rsp_valid) break;
        end
        if (k == 200) chk("drain_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_req(input int id, input int n);
        for (int k = 0; k < n; k++) begin
            issue(id, DW'(k * 10 + id + 1), DW'(k + 2), AC'(k % 5));
            wait_ready(id);
        end
        drop(id);
    endtask

    logic [DW-1:0] held;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_req_ready", {62'd0, req_ready}, 64'd0);
        chk("rst_rsp_data", {32'd0, rsp_data}, 64'd0);
        rst = 1'b0;

        // Single op from req0: accept, one EXEC cycle, then the response.
        @(posedge clk); #1;
        issue(0, 32'd5, 32'd7, 4'd0);
        @(negedge clk);
        chk("single_ready", {62'd0, req_ready}, 64'd1);
        @(posedge clk); #1;
        drop(0);
        @(negedge clk);
        chk("single_exec_valid", {63'd0, rsp_valid}, 64'd0);
        chk("single_alu_a", {32'd0, alu_a}, 64'd5);
        chk("single_alu_b", {32'd0, alu_b}, 64'd7);
        @(negedge clk);
        chk("single_valid", {63'd0, rsp_valid}, 64'd1);
        chk("single_id", {63'd0, rsp_id}, 64'd0);
        chk("single_data", {32'd0, rsp_data}, 64'd12);
        @(posedge clk); #1;

        // Operands must stay latched even if the requester changes its payload.
        issue(1, 32'hFFFF_FFFF, 32'd1, 4'd0);
        wait_ready(1);
        drop(1);
        a1 = 32'h1234_5678;
        @(negedge clk);
        chk("stab_alu_a", {32'd0, alu_a}, 64'hFFFF_FFFF);
        @(negedge clk);
        chk("stab_data", {32'd0, rsp_data}, 64'd0);
        chk("stab_id", {63'd0, rsp_id}, 64'd1);
        drain();

        // Backpressure: response held 5 cycles while req1 waits.
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        issue(0, 32'd100, 32'd30, 4'd1);
        wait_ready(0);
        drop(0);
        issue(1, 32'h0000_F0F0, 32'h0000_0FF0, 4'd2);
        wait_rsp();
        held = rsp_data;
        chk("bp_first_data", {32'd0, held}, 64'd70);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_data_stable", {32'd0, rsp_data}, {32'd0, held});
            chk("bp_valid_held", {63'd0, rsp_valid}, 64'd1);
            chk("bp_no_ready", {62'd0, req_ready}, 64'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_hs_no_ready", {62'd0, req_ready}, 64'd0);
        @(negedge clk);
        chk("bp_grant1", {62'd0, req_ready}, 64'd2);
        @(posedge clk); #1;
        drop(1);
        drain();

        // Reset in the middle of RESP discards the in-flight op.
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        issue(0, 32'd3, 32'd4, 4'd4);
        wait_ready(0);
        drop(0);
        wait_rsp();
        issue(1, 32'd9, 32'd9, 4'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("midrst_req_ready", {62'd0, req_ready}, 64'd0);
        chk("midrst_rsp_data", {32'd0, rsp_data}, 64'd0);
        rsp_ready = 1'b1;

        // Contention right out of reset: grants must go 0,1,0,1,...
        fork
            run_req(0, 4);
            run_req(1, 4);
            begin
                repeat (2) @(posedge clk);
                #1;
                rst = 1'b0;
            end
        join
        drain();
        chk("cont_grants", 64'(glog.size()), 64'd8);
        for (int i = 0; i < glog.size(); i++)
            chk("cont_order", {63'd0, glog[i]}, 64'(i % 2));

        // Idle: nothing requested, nothing happens.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_ready", {62'd0, req_ready}, 64'd0);
            chk("idle_valid", {63'd0, rsp_valid}, 64'd0);
        end
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
